mult_seq_gen: RTL

MULT_SEQ_GEN -- requirements
Module: mult_seq_gen

---
 rtl/mult_seq_gen.sv | 110 +++++++++++
 1 files changed

// File: rtl/mult_seq_gen.sv
// Sequential shift-and-add multiplier producing one 2*WIDTH product per WIDTH+2 cycles.
// Signed operands are reduced to magnitudes up front. The result sign is applied in a single fix-up cycle.
module mult_seq_gen #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 sgn,
  input  logic [WIDTH-1:0]     mlier,
  input  logic [WIDTH-1:0]     mcand,
  output logic                 ready,
  output logic                 valid,
  output logic [2*WIDTH-1:0]   prodt
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W   = (2*WIDTH)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_count;
  logic [WIDTH-1:0]     r_mlier;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_prodt;
  logic                 r_neg;
  logic                 r_valid;
  logic                 w_accept;
  logic                 w_last;

  // Magnitude fits in WIDTH unsigned bits, including for the most negative value.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic s);
    return (s && x[WIDTH-1]) ? (~x + ONE_W) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] acc, input logic neg);
    return (neg && (acc != '0)) ? (~acc + ONE_2W) : acc;
  endfunction

  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_count == CNT_ONE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = FIX;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
      r_count <= '0;
      r_acc   <= '0;
      r_prodt <= '0;
      r_valid <= 1'b0;
      r_neg   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_neg   <= sgn & (mlier[WIDTH-1] ^ mcand[WIDTH-1]);
            r_acc   <= '0;
            r_count <= CNT_LOAD;
          end
        end
        RUN: begin
          if (r_mlier[0]) r_acc <= r_acc + r_mcand;
          r_count <= r_count - CNT_ONE;
        end
        FIX: begin
          r_prodt <= apply_sign(r_acc, r_neg);
          r_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Operand shift registers carry no reset; they are always reloaded on accept.
  always_ff @(posedge clock) begin
    if (w_accept && reset) begin
      r_mlier <= magnitude(mlier, sgn);
      r_mcand <= {{WIDTH{1'b0}}, magnitude(mcand, sgn)};
    end else if (r_state == RUN) begin
      r_mlier <= r_mlier >> 1;
      r_mcand <= r_mcand << 1;
    end
  end

  assign ready = (r_state == IDLE);
  assign valid = r_valid;
  assign prodt = r_prodt;

endmodule
